gj_inv_seq: RTL and testbench
=============================

# gj_inv_seq

Sequential Gauss-Jordan inversion controller for N×N signed integer matrices in the linear-algebra datapath. It accepts a matrix as a row-major element stream, builds the augmented [A | I] array internally, and performs one row-operation element per clock through a shared divide / multiply-subtract unit. It then streams the right half (A⁻¹) out row-major. It replaces the fully unrolled combinational inverter wherever area matters more than latency.

## Interface
- N, default 5: matrix dimension; augmented array is N×2N.
- W, default 32: element width, two's-complement signed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input element valid.
- in_ready  out  1  block accepts input; high only in LOAD.
- in_data  in  W  input element, row-major a[0][0]..a[N-1][N-1].
- out_valid  out  1  output element valid; high only in OUT.
- out_ready  in  1  downstream accepts output.
- out_data  out  W  inverse element, row-major inv[0][0]..inv[N-1][N-1].
- out_last  out  1  high with the final (N·N-th) output element.
- err  out  1  zero pivot was detected for the current matrix; held through OUT.
- busy  out  1  high in PIVOT, NORM, FACT and ELIM.

## Operation
- Reset: enters LOAD. in_ready=1, out_valid=0, out_data=0, out_last=0, err=0, busy=0. Matrix storage is not reset.
- LOAD: each in_valid&in_ready handshake writes m[r][c]. On the same write, the right half is set to the identity row. After the N·N-th handshake, go to PIVOT with k=0 and clear err.
- PIVOT, 1 cycle: latch p=m[k][k].
  - If p==0: set err and go to OUT. The array is left as is.
  - Otherwise go to NORM with j=0.
- NORM, 2N cycles: m[k][j] = m[k][j] / p, one j per cycle, j=0..2N-1. The latched p is used, so overwriting m[k][k] is safe. Then go to FACT with i = first row ≠ k.
- FACT, 1 cycle: latch f=m[i][k], then go to ELIM with j=0.
- ELIM, 2N cycles: m[i][j] = m[i][j] − f·m[k][j], j=0..2N-1. Then i advances to the next row ≠ k.
  - If no rows remain: k++. If k==N go to OUT, else go to PIVOT.
- OUT: presents m[r][N+c] row-major. The element index advances only on out_valid&out_ready; data is held stable while stalled. After the handshake on the out_last element, go to LOAD.
- Arithmetic:
  - Division is signed, truncating toward zero.
  - Product and difference are truncated to W bits (wrap, no saturation).
  - Results are exact only for unimodular inputs.
- in_valid outside LOAD is ignored (in_ready=0). out_ready outside OUT is ignored.
- Reset mid-operation, any state: immediate return to LOAD with the reset values above. A partially loaded or processed matrix is discarded.

## Timing
- Input: at most one element per cycle; N·N cycles minimum.
- Compute latency, last input handshake to first out_valid: N·(1 + 2N + (N−1)·(1+2N)) cycles. For N=5 this is 275.
- Zero pivot at step k: out_valid follows the PIVOT cycle of step k by 1 cycle.
- Output: one element per cycle when out_ready is held high. out_data/out_last are registered.

## Configuration
- GJ_SKIP_ZERO_EN defined: in FACT, if f==0 the ELIM pass for that row is skipped, so that row costs 1 cycle instead of 1+2N. The identity input then takes N·(1+2N+(N−1)) = 75 cycles for N=5.
- Undefined: every row is eliminated unconditionally; latency is fixed as in Timing.
- Output values are identical either way.

## Structure
- Package gj_pkg:
  - state enum {LOAD, PIVOT, NORM, FACT, ELIM, OUT};
  - default N/W constants;
  - index-width function clog2-based for r, c, i, j, k.
- Sub-module gj_row_alu, combinational:
  - inputs op (div / msub), a, b, s; output y.
  - div gives a/s; msub gives a − s·b, truncated to W.
  - Instantiated once; the controller time-multiplexes it.

## Test plan
- Identity 5×5, out_ready=1 → output equals identity; first out_valid is 275 cycles after the last input (75 with GJ_SKIP_ZERO_EN); err=0; out_last on the 25th word only.
- diag(1,1,1) with block [[1,4],[2,9]] in rows/cols 3-4 → inverse block [[9,−4],[−2,1]], rest identity, err=0.
- All-zero matrix → err=1, OUT entered 1 cycle after the first PIVOT, 25 words streamed, return to LOAD.
- Backpressure: out_ready low for 3 cycles mid-stream → out_data/out_valid stable, no word lost or duplicated.
- rst pulsed during ELIM → in_ready=1, busy=0, err=0 immediately. A following identity load yields a correct identity output.
- in_valid held high during compute → no writes (in_ready=0), and the result is unchanged.

Source files
------------

// File: rtl/gj_pkg.sv
// gj_pkg: shared state encoding, ALU opcodes, default sizes and index-width helper for gj_inv_seq.
package gj_pkg;
  localparam int N_DEF = 5;
  localparam int W_DEF = 32;
  typedef enum logic [2:0] {LOAD, PIVOT, NORM, FACT, ELIM, OUT} state_t;
  typedef enum logic {OP_DIV, OP_MSUB} op_t;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/gj_row_alu.sv
// gj_row_alu: combinational row-operation unit; div gives a/s, msub gives a - s*b (both truncated to W bits).
// Ports: op (OP_DIV/OP_MSUB), a, b, s operands, y result.
module gj_row_alu
  import gj_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  op_t                 op,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] s,
  output logic signed [W-1:0] y
);
  logic signed [W-1:0] q, d;
  assign q = a / s;
  assign d = a - s * b;
  assign y = (op == OP_DIV) ? q : d;
endmodule

// File: rtl/gj_inv_seq.sv
// gj_inv_seq: sequential Gauss-Jordan inverter for NxN signed matrices, one row-op element per clock.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data row-major matrix input;
//        out_valid/out_ready/out_data/out_last row-major inverse output; err zero pivot; busy computing.
// Option: GJ_SKIP_ZERO_EN skips the elimination pass of rows whose factor is zero.
module gj_inv_seq
  import gj_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         err,
  output logic         busy
);
  localparam int RW = idx_w(N);
  localparam int JW = idx_w(2 * N);
  state_t state, nxt;
  logic [RW-1:0] r, c, k, i, ni, rn, cn;
  logic [JW-1:0] j, oc;
  logic signed [W-1:0] m [N][2*N];
  logic signed [W-1:0] p, f, a, b, s, y;
  op_t op;
  logic acc, ohs, j_end, c_end, r_end, k_end, i_end, skip, adv, enter_out;
  assign in_ready  = state == LOAD;
  assign out_valid = state == OUT;
  assign busy      = state inside {PIVOT, NORM, FACT, ELIM};
  assign acc       = in_valid & in_ready;
  assign ohs       = out_valid & out_ready;
  assign j_end     = j == JW'(2 * N - 1);
  assign c_end     = c == RW'(N - 1);
  assign r_end     = r == RW'(N - 1);
  assign k_end     = k == RW'(N - 1);
  // the pivot row k is never eliminated, so the last row to visit is N-2 when k is N-1
  assign i_end     = (i == RW'(N - 1)) || (k_end && i == RW'(N - 2));
  assign ni        = (i + 1'b1 == k) ? k + 1'b1 : i + 1'b1;
  assign cn        = c_end ? '0 : c + 1'b1;
  assign rn        = c_end ? r + 1'b1 : r;
  assign oc        = JW'(N) + JW'(cn);
`ifdef GJ_SKIP_ZERO_EN
  assign skip = m[i][JW'(k)] == '0;
`else
  assign skip = 1'b0;
`endif
  assign adv       = (state == ELIM && j_end) || (state == FACT && skip);
  assign enter_out = nxt == OUT && state != OUT;
  assign op = (state == NORM) ? OP_DIV : OP_MSUB;
  assign a  = (state == NORM) ? m[k][j] : m[i][j];
  assign b  = m[k][j];
  assign s  = (state == NORM) ? p : f;
  gj_row_alu #(.W(W)) u_alu (.op(op), .a(a), .b(b), .s(s), .y(y));
  always_comb begin
    nxt = state;
    unique case (state)
      LOAD:  nxt = (acc && r_end && c_end) ? PIVOT : LOAD;
      PIVOT: nxt = (m[k][JW'(k)] == '0) ? OUT : NORM;
      NORM:  nxt = j_end ? FACT : NORM;
      FACT:  nxt = skip ? (i_end ? (k_end ? OUT : PIVOT) : FACT) : ELIM;
      ELIM:  nxt = j_end ? (i_end ? (k_end ? OUT : PIVOT) : FACT) : ELIM;
      OUT:   nxt = (ohs && out_last) ? LOAD : OUT;
      default: nxt = LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      r        <= '0;
      c        <= '0;
      k        <= '0;
      i        <= '0;
      j        <= '0;
      p        <= '0;
      f        <= '0;
      err      <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= nxt;
      unique case (state)
        LOAD: if (acc) begin
          c <= cn;
          r <= (r_end && c_end) ? '0 : rn;
          if (r_end && c_end) begin
            k   <= '0;
            err <= 1'b0;
          end
        end
        PIVOT: begin
          p <= m[k][JW'(k)];
          j <= '0;
          if (m[k][JW'(k)] == '0) err <= 1'b1;
        end
        NORM: begin
          j <= j_end ? '0 : j + 1'b1;
          if (j_end) i <= (k == '0) ? RW'(1) : '0;
        end
        FACT: begin
          f <= m[i][JW'(k)];
          j <= '0;
        end
        ELIM: j <= j_end ? '0 : j + 1'b1;
        OUT: if (ohs) begin
          c        <= out_last ? '0 : cn;
          r        <= out_last ? '0 : rn;
          out_data <= out_last ? '0 : m[rn][oc];
          out_last <= !out_last && rn == RW'(N - 1) && cn == RW'(N - 1);
        end
        default: ;
      endcase
      if (adv) begin
        if (i_end) k <= k + 1'b1;
        else i <= ni;
      end
      // the final elimination write never targets m[0][N] (N >= 2), so this read is already up to date
      if (enter_out) begin
        out_data <= m[0][JW'(N)];
        out_last <= N == 1;
      end
    end
  end
  // matrix storage is deliberately unreset; a load rewrites every element that is later used
  always_ff @(posedge clk) begin
    if (acc) begin
      m[r][JW'(c)] <= in_data;
      for (int x = 0; x < N; x++) m[r][JW'(N + x)] <= (RW'(x) == r) ? W'(1) : '0;
    end else if (state == NORM) m[k][j] <= y;
    else if (state == ELIM) m[i][j] <= y;
  end
endmodule

// File: tb/tb_gj_inv_seq.sv
// tb_gj_inv_seq: scoreboard bench for gj_inv_seq with directed matrices and hand-computed inverses.
module tb_gj_inv_seq;
  localparam int N = 5, W = 32, NN = N * N;
`ifdef GJ_SKIP_ZERO_EN
  localparam int LAT_ID = 75;
`else
  localparam int LAT_ID = 275;
`endif
  logic clk = 0, rst, in_valid, in_ready, out_valid, out_ready, out_last, err, busy;
  logic [W-1:0] in_data, out_data;
  typedef struct packed {logic [W-1:0] d; logic l; logic e;} exp_t;
  exp_t sb[$];
  exp_t cur;
  int vecs = 0, errs = 0;
  logic hold_chk = 0;
  logic [W-1:0] hold_d;
  always #5 clk = ~clk;
  gj_inv_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .busy(busy)
  );
  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, $signed(act), $signed(exp), $time);
    end
  endtask
  always @(negedge clk) begin
    if (hold_chk) begin
      chk("stall_data", out_data, hold_d);
      chk("stall_valid", W'(out_valid), W'(1));
    end
    hold_chk = out_valid && !out_ready;
    hold_d   = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_output", W'(out_valid), W'(0));
      else begin
        cur = sb.pop_front();
        chk("out_data", out_data, cur.d);
        chk("out_last", W'(out_last), W'(cur.l));
        chk("err", W'(err), W'(cur.e));
      end
    end
  end
  task automatic expect_mat(input int inv[NN], input logic er);
    for (int x = 0; x < NN; x++) sb.push_back('{d: W'(inv[x]), l: (x == NN - 1), e: er});
  endtask
  task automatic load(input int a[NN], input logic hold);
    chk("in_ready_at_load", W'(in_ready), W'(1));
    for (int x = 0; x < NN; x++) begin
      in_valid = 1;
      in_data  = W'(a[x]);
      @(posedge clk);
      #1;
    end
    if (hold) in_data = 77;
    else in_valid = 0;
  endtask
  task automatic run(input int a[NN], input int inv[NN], input logic er, input int lat, input logic hold, input logic bp);
    int cnt;
    expect_mat(inv, er);
    load(a, hold);
    cnt = 0;
    while (!out_valid && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (hold && cnt == 3) chk("in_ready_busy", W'(in_ready), W'(0));
    end
    in_valid = 0;
    if (lat >= 0) chk("latency", W'(cnt), W'(lat));
    cnt = 0;
    while (sb.size() != 0 && cnt < 200) begin
      out_ready = !(bp && cnt >= 5 && cnt < 8);
      @(posedge clk);
      #1;
      cnt++;
    end
    out_ready = 1;
    chk("drained", W'(sb.size()), W'(0));
    chk("back_to_load", W'(in_ready), W'(1));
    chk("out_valid_after", W'(out_valid), W'(0));
  endtask
  function automatic void ident(output int x[NN]);
    for (int q = 0; q < NN; q++) x[q] = (q % (N + 1) == 0) ? 1 : 0;
  endfunction
  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int id[NN], z[NN], blk[NN], blk_i[NN], up[NN], up_i[NN], dg[NN], dg_i[NN];
    rst = 1; in_valid = 0; in_data = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    rst = 0;
    ident(id);
    foreach (z[q]) z[q] = 0;
    ident(blk); ident(blk_i);
    blk[18] = 1; blk[19] = 4; blk[23] = 2; blk[24] = 9;
    blk_i[18] = 9; blk_i[19] = -4; blk_i[23] = -2; blk_i[24] = 1;
    ident(up); ident(up_i);
    up[1] = 2; up[6] = -1; up[7] = 3;
    up_i[1] = 2; up_i[2] = -6; up_i[6] = -1; up_i[7] = 3;
    ident(dg); ident(dg_i);
    dg[0] = -3; dg_i[0] = 0;
    run(id, id, 0, LAT_ID, 0, 0);
    run(blk, blk_i, 0, -1, 0, 1);
    run(up, up_i, 0, -1, 0, 0);
    run(dg, dg_i, 0, -1, 0, 0);
    run(z, id, 1, 1, 0, 0);
    load(up, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_before_abort", W'(busy), W'(1));
    rst = 1;
    #1;
    chk("abort_in_ready", W'(in_ready), W'(1));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_err", W'(err), W'(0));
    chk("abort_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    run(id, id, 0, LAT_ID, 0, 0);
    run(up, up_i, 0, -1, 1, 0);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
